if_fetch_unit: RTL
==================

// Module: if_fetch_unit
// PURPOSE
//  Instruction fetch stage. Holds the architectural fetch PC and drives it to the branch predictor
//  (combinational pc_i -> pc_o1/predict_result path). Issues one-at-a-time fetch requests to the icache.
//  Tags each returned instruction with its PC and prediction, and buffers it in an instruction queue for decode.
//  A redirect from the commit/branch-resolve logic flushes the queue and restarts fetch at the correct PC.
// PARAMETERS
//  IQ_DEPTH   16  instruction queue entries (power of two, >=2)
//  ADDR_W     32  PC / address width
//  INST_W     32  instruction width
// PORTS
//  clk            in   1       clock; all state updates on posedge
//  rst            in   1       synchronous, active-high reset
//  bp_pc          out  ADDR_W  current fetch PC to predictor (= pc register)
//  bp_npc         in   ADDR_W  predicted next PC for bp_pc (combinational from predictor)
//  bp_taken       in   1       predicted taken for bp_pc
//  ic_req         out  1       fetch request; held high until ic_valid
//  ic_addr        out  ADDR_W  fetch address; stable while ic_req high
//  ic_valid       in   1       one-cycle pulse: ic_inst is data for the outstanding request
//  ic_inst        in   INST_W  fetched instruction
//  iq_valid       out  1       queue head valid
//  iq_inst        out  INST_W  head instruction
//  iq_pc          out  ADDR_W  head PC
//  iq_pred_taken  out  1       head predicted-taken bit
//  iq_pred_npc    out  ADDR_W  head predicted next PC
//  iq_pop         in   1       decode consumes head this cycle (ignored if !iq_valid)
//  flush          in   1       mispredict/redirect
//  flush_pc       in   ADDR_W  restart PC, valid with flush
// BEHAVIOUR
//  Reset: pc=0, queue empty (count=0, head=tail=0), state IDLE, ic_req=0, iq_valid=0, iq_* data=0.
//  Head outputs are combinational from queue storage; iq_valid = (count!=0).
//  FSM: IDLE, WAIT, DROP.
//   IDLE: if !flush && count<IQ_DEPTH -> ic_req=1, ic_addr=pc, go WAIT (ic_req asserted from next cycle).
//   WAIT: ic_req=1, ic_addr=pc. On ic_valid (no flush): push {ic_inst, pc, bp_taken, bp_npc}, pc<=bp_npc, -> IDLE.
//   DROP: ic_req=0. Wait for ic_valid of abandoned request, discard it, -> IDLE.
//  Request is issued only when count<IQ_DEPTH; the slot is reserved, so push never overflows.
//  Fetch issue latency: 1 cycle from IDLE to ic_req high; pushed entry visible on iq_valid the cycle after ic_valid.
//  Push/pop same cycle: both take effect, count unchanged. Pop with count==0 ignored.
//  Pointers wrap modulo IQ_DEPTH; count width clog2(IQ_DEPTH)+1.
//  flush (highest priority, any state): queue cleared, pc<=flush_pc, pop/push that cycle discarded.
//   flush in WAIT with ic_valid same cycle: data dropped, -> IDLE. flush in WAIT without ic_valid: -> DROP.
//   flush in DROP: pc<=flush_pc, stay DROP. flush in IDLE: stay IDLE.
//  Prediction is sampled at push time from the predictor's combinational output for pc.
//  rst mid-request: FSM to IDLE immediately; icache is reset by the same rst.
// STRUCTURE
//  Shared config.v: InstAddrBus/InstBus widths, IQ_DEPTH default, IQ entry field layout, FSM state encoding.
//  Sub-module inst_queue: synchronous FIFO (push/pop/clear, count, head read), instantiated once.
//  Top holds pc register, FSM, and request/flush control.
// TESTING
//  1 Reset, icache returns 0x00000013 after 2 cycles, bp_taken=0 -> entry pc=0x0, next ic_addr=0x4.
//  2 bp_taken=1, bp_npc=0x100 at pc=0x8 -> entry pred_taken=1, pred_npc=0x100; next ic_addr=0x100.
//  3 Never pop: after 16 pushes ic_req stays 0; one pop -> exactly one new request issued.
//  4 flush_pc=0x200 while WAIT -> late ic_valid discarded, iq_valid=0, next ic_addr=0x200.
//  5 flush coincident with ic_valid and iq_pop, count=3 -> count=0, pc=flush_pc, no push.
//  6 count=5, push and pop same cycle -> count stays 5; FIFO order preserved across pointer wrap.

Source files
------------

// File: rtl/if_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch stage: default widths, queue depth
// and the fetch FSM state encoding.
package if_fetch_unit_pkg;

    localparam int ADDR_W_DEF   = 32;
    localparam int INST_W_DEF   = 32;
    localparam int IQ_DEPTH_DEF = 16;

    // Queue entry layout, MSB first: {inst, pc, pred_taken, pred_npc}
    localparam int PRED_TAKEN_W = 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DROP = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/if_fetch_unit_inst_queue.sv
// Instruction queue: synchronous FIFO with push, pop, clear and a combinational head.
// Pointers wrap naturally because DEPTH is a power of two.
module inst_queue #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 97
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     valid
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    head;
    logic [PW-1:0]    tail;
    logic             pop_eff;
    logic             push_eff;

    assign pop_eff   = pop && (count != '0);
    assign push_eff  = push && ((count != FULL_CNT) || pop_eff);
    assign head_data = mem[head];
    assign valid     = (count != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (clear) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push_eff) begin
                mem[tail] <= push_data;
                tail      <= tail + 1'b1;
            end
            if (pop_eff) begin
                head <= head + 1'b1;
            end
            case ({push_eff, pop_eff})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, issues one icache request at a time,
// tags returned instructions with PC and prediction, and buffers them for decode.
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter int IQ_DEPTH = IQ_DEPTH_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int INST_W   = INST_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] bp_pc,
    input  logic [ADDR_W-1:0] bp_npc,
    input  logic              bp_taken,
    output logic              ic_req,
    output logic [ADDR_W-1:0] ic_addr,
    input  logic              ic_valid,
    input  logic [INST_W-1:0] ic_inst,
    output logic              iq_valid,
    output logic [INST_W-1:0] iq_inst,
    output logic [ADDR_W-1:0] iq_pc,
    output logic              iq_pred_taken,
    output logic [ADDR_W-1:0] iq_pred_npc,
    input  logic              iq_pop,
    input  logic              flush,
    input  logic [ADDR_W-1:0] flush_pc,
    output logic [1:0]        fsm_state
);

    localparam int EW = INST_W + 2 * ADDR_W + PRED_TAKEN_W;
    localparam int CW = $clog2(IQ_DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_CNT = CW'(IQ_DEPTH);

    fetch_state_e      state;
    fetch_state_e      state_nx;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_nx;
    logic              q_push;
    logic              q_clear;
    logic [EW-1:0]     q_head;
    logic [CW-1:0]     q_count;

    // Handshakes: ic_req stays high with ic_addr stable until the single-cycle ic_valid
    // answers it; an abandoned request is still answered and swallowed in DROP.
    // iq_valid/iq_pop: the head is consumed on any cycle where both are high.
    assign ic_req    = (state == ST_WAIT);
    assign ic_addr   = pc;
    assign bp_pc     = pc;
    assign fsm_state = state;
    assign {iq_inst, iq_pc, iq_pred_taken, iq_pred_npc} = q_head;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            pc    <= '0;
        end else begin
            state <= state_nx;
            pc    <= pc_nx;
        end
    end

    always_comb begin
        state_nx = state;
        pc_nx    = pc;
        q_push   = 1'b0;
        q_clear  = flush;
        if (flush) begin
            pc_nx = flush_pc;
        end
        case (state)
            ST_IDLE: begin
                // Issue only with a free slot, so the eventual push can never overflow.
                if (!flush && (q_count < DEPTH_CNT)) begin
                    state_nx = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (flush) begin
                    state_nx = ic_valid ? ST_IDLE : ST_DROP;
                end else if (ic_valid) begin
                    q_push   = 1'b1;
                    pc_nx    = bp_npc;
                    state_nx = ST_IDLE;
                end
            end
            ST_DROP: begin
                if (ic_valid) begin
                    state_nx = ST_IDLE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    inst_queue #(
        .DEPTH (IQ_DEPTH),
        .WIDTH (EW)
    ) u_inst_queue (
        .clk       (clk),
        .rst       (rst),
        .clear     (q_clear),
        .push      (q_push),
        .push_data ({ic_inst, pc, bp_taken, bp_npc}),
        .pop       (iq_pop && !flush),
        .head_data (q_head),
        .count     (q_count),
        .valid     (iq_valid)
    );

endmodule
